multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multicycle sequencer for the single-ALU MIPS-subset datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Drives the same datapath controls as the combinational decoder (wreg, m2reg, wmem, aluimm, regrt, aluc), plus PC/IR enables and a ready/request handshake to a shared instruction/data memory. Sits between the IR fields (op/func) and the datapath muxes and enables.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before entering ERROR; 0 disables the timeout.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
op  in  6  opcode field from IR
func  in  6  funct field from IR
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  memory write (store), valid with mem_req
iord  out  1  0 = PC address, 1 = ALU address
ir_write  out  1  load IR
pc_write  out  1  PC <= PC+4
wreg  out  1  register file write
m2reg  out  1  1 = writeback from memory, 0 = from ALU
wmem  out  1  store in progress
aluimm  out  1  ALU B = sign-extended immediate
regrt  out  1  destination is rt (1) or rd (0)
aluc  out  4  ALU op: 0010 add, 0110 sub
state  out  3  current state encoding
err  out  1  sticky error
trap  out  1  illegal-instruction trap (see Optional Feature)
retired  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5, TRAP=6.
- Reset (sync, rst=1 at a clock edge): state=FETCH, retired=0, class=NOP, err=0, trap=0, timeout counter=0. Every output not listed is 0. Reset overrides all events in the same cycle, including a mid-access mem_ready.
- Class register: captured in DECODE from op/func:
  - ADD (op 000000, func 100000)
  - SUB (op 000000, func 100010)
  - LW (op 100011)
  - SW (op 101011)
  - anything else = ILLEGAL
- FETCH: mem_req=1, iord=0, mem_we=0.
  - mem_ready=1: ir_write=1 and pc_write=1 combinationally in that same cycle; go to DECODE.
  - Otherwise stay.
- DECODE: one cycle, latch class.
  - ILLEGAL: see Optional Feature.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - ADD: aluimm=0, aluc=0010.
  - SUB: aluimm=0, aluc=0110.
  - LW/SW: aluimm=1, aluc=0010.
  - Next: ADD/SUB go to WB; LW/SW go to MEM.
- MEM: mem_req=1, iord=1, aluimm=1, aluc=0010.
  - SW: mem_we=1, wmem=1.
  - mem_ready=1: LW goes to WB; SW goes to FETCH and retired increments.
- WB: wreg=1 for exactly one cycle.
  - LW: m2reg=1, regrt=1.
  - ADD/SUB: m2reg=0, regrt=0.
  - Next: FETCH; retired increments.
- Outside these states, wreg/ir_write/pc_write/mem_req are 0; aluc=0010; m2reg/regrt=0.
- Latency with zero-wait memory (mem_ready high in the first request cycle): ADD/SUB 4 cycles, LW 5, SW 4. Each wait cycle adds 1.
- Timeout counter:
  - Counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or any state change.
  - Reaching MEM_TIMEOUT (when nonzero): go to ERROR, err=1.
- ERROR: all enables 0, err=1; stays until rst.
- retired wraps modulo 2^CNT_W.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: DECODE with ILLEGAL class goes to TRAP. TRAP holds all enables 0, trap=1, sticky until rst. retired is not incremented.
- Undefined: ILLEGAL is a NOP. DECODE goes to FETCH, retired increments, and trap is tied to 0. The TRAP encoding is unreachable.

Test Plan:
- ADD (op=0, func=0x20), mem_ready tied 1 -> states 0,1,2,4,0; wreg=1 in WB only, aluc=0010, regrt=0; retired 0->1 after 4 cycles.
- SUB then LW, zero-wait -> SUB EXEC aluc=0110. LW passes through MEM with iord=1, mem_we=0; LW WB has m2reg=1, regrt=1; 9 cycles total; retired=2.
- SW with mem_ready delayed 3 cycles in MEM -> mem_req=mem_we=wmem=1 held 4 cycles; no WB; back to FETCH; wreg never 1.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> ERROR after 4 request cycles; err=1, mem_req=0; stays until rst; rst then returns state=0, err=0.
- op=0x3F with ILLEGAL_TRAP_EN -> trap=1 in the cycle after DECODE, retired unchanged. Without the macro -> DECODE->FETCH, retired+1, trap=0.
- rst asserted in MEM of LW with mem_ready=1 the same cycle -> next state FETCH, retired=0, no WB, wreg=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the multicycle sequencer
// (master) and the memory port (slave).
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output iord,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  iord,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-ALU MIPS subset.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap instead of retiring as NOPs.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          op,
   input  logic [5:0]          func,
   multicycle_ctrl_if.master   mem,
   output logic                ir_write,
   output logic                pc_write,
   output logic                wreg,
   output logic                m2reg,
   output logic                wmem,
   output logic                aluimm,
   output logic                regrt,
   output logic [3:0]          aluc,
   output logic [2:0]          state,
   output logic                err,
   output logic                trap,
   output logic [CNT_W-1:0]    retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERROR  = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_NOP = 3'd0,
      C_ADD = 3'd1,
      C_SUB = 3'd2,
      C_LW  = 3'd3,
      C_SW  = 3'd4,
      C_ILL = 3'd5
   } class_t;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // Wide enough to hold MEM_TIMEOUT itself; one bit when the timeout is disabled.
   localparam int              TW     = $clog2(MEM_TIMEOUT + 2);
   localparam logic [TW-1:0]   TLIMIT = TW'(MEM_TIMEOUT);

   state_t            state_reg, state_next;
   class_t            class_reg, class_next;
   class_t            decoded;
   logic [TW-1:0]     tcnt_reg, tcnt_next;
   logic [CNT_W-1:0]  retired_reg, retired_next;
   logic              mreq, mwe, miord;

   always_comb begin
      decoded = C_ILL;
      case (op)
         6'b000000: begin
            if (func == 6'b100000)
               decoded = C_ADD;
            else if (func == 6'b100010)
               decoded = C_SUB;
            else
               decoded = C_ILL;
         end
         6'b100011: decoded = C_LW;
         6'b101011: decoded = C_SW;
         default:   decoded = C_ILL;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      class_next   = class_reg;
      retired_next = retired_reg;
      tcnt_next    = '0;
      mreq         = 1'b0;
      mwe          = 1'b0;
      miord        = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      wreg         = 1'b0;
      m2reg        = 1'b0;
      wmem         = 1'b0;
      aluimm       = 1'b0;
      regrt        = 1'b0;
      aluc         = ALU_ADD;

      case (state_reg)
         S_FETCH: begin
            mreq = 1'b1;
            if (mem.mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            class_next = decoded;
            if (decoded == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
               state_next = S_TRAP;
`else
               state_next   = S_FETCH;
               retired_next = retired_reg + 1'b1;
`endif
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            case (class_reg)
               C_ADD: state_next = S_WB;
               C_SUB: begin
                  aluc       = ALU_SUB;
                  state_next = S_WB;
               end
               C_LW, C_SW: begin
                  aluimm     = 1'b1;
                  state_next = S_MEM;
               end
               default: state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            mreq   = 1'b1;
            miord  = 1'b1;
            aluimm = 1'b1;
            if (class_reg == C_SW) begin
               mwe  = 1'b1;
               wmem = 1'b1;
            end
            if (mem.mem_ready) begin
               if (class_reg == C_SW) begin
                  state_next   = S_FETCH;
                  retired_next = retired_reg + 1'b1;
               end else begin
                  state_next = S_WB;
               end
            end
         end
         S_WB: begin
            wreg = 1'b1;
            if (class_reg == C_LW) begin
               m2reg = 1'b1;
               regrt = 1'b1;
            end
            state_next   = S_FETCH;
            retired_next = retired_reg + 1'b1;
         end
         default: ;
      endcase

      // A stalled request never changes state, so the counter only runs while parked.
      if (mreq && !mem.mem_ready) begin
         tcnt_next = tcnt_reg + 1'b1;
         if (MEM_TIMEOUT != 0 && tcnt_next == TLIMIT) begin
            state_next = S_ERROR;
            tcnt_next  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_FETCH;
         class_reg   <= C_NOP;
         tcnt_reg    <= '0;
         retired_reg <= '0;
      end else begin
         state_reg   <= state_next;
         class_reg   <= class_next;
         tcnt_reg    <= tcnt_next;
         retired_reg <= retired_next;
      end
   end

   assign mem.mem_req = mreq;
   assign mem.mem_we  = mwe;
   assign mem.iord    = miord;
   assign state       = state_reg;
   assign retired     = retired_reg;
   assign err         = (state_reg == S_ERROR);
`ifdef ILLEGAL_TRAP_EN
   assign trap        = (state_reg == S_TRAP);
`else
   assign trap        = 1'b0;
`endif

endmodule
